// File: rtl/ysyx_ifu_pkg.sv
// ============================================================================
// ysyx_ifu_pkg: shared reset PC, IFU state encoding and NOP constant.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ysyx_ifu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } ifu_state_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_ifu_if.sv
// ============================================================================
// ysyx_ifu_if: instruction-memory, decode and redirect signals of the IFU.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ysyx_ifu_if #(
  parameter int ADDR_W = 32
);

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
           redirect_valid, redirect_pc
  );

endinterface

`default_nettype wire

// File: rtl/ysyx_ifu_fsm.sv
// ============================================================================
// ysyx_ifu_fsm: fetch state, wrong-path drop flag and handshake decode.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_ifu_fsm
  import ysyx_ifu_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_ready,
  input  logic rsp_valid,
  input  logic out_ready,
  input  logic redirect_valid,
  output logic req_valid,
  output logic out_valid,
  output logic rsp_take,
  output logic out_fire
`ifdef YSYX_IFU_PERF_EN
  ,
  output logic in_wait
`endif
);

  ifu_state_e state, state_n;
  logic       drop, drop_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      drop  <= 1'b0;
    end else begin
      state <= state_n;
      drop  <= drop_n;
    end
  end

  always_comb begin
    state_n   = state;
    drop_n    = drop;
    req_valid = 1'b0;
    out_valid = 1'b0;
    rsp_take  = 1'b0;
    out_fire  = 1'b0;
    case (state)
      S_REQ: begin
        req_valid = ~rst;
        // A request accepted alongside a redirect fetches the old path.
        if (req_ready) begin
          state_n = S_WAIT;
          if (redirect_valid) drop_n = 1'b1;
        end
      end
      S_WAIT: begin
        if (rsp_valid) begin
          if (drop || redirect_valid) begin
            drop_n  = 1'b0;
            state_n = S_REQ;
          end else begin
            rsp_take = 1'b1;
            state_n  = S_HOLD;
          end
        end else if (redirect_valid) begin
          drop_n = 1'b1;
        end
      end
      S_HOLD: begin
        out_valid = ~redirect_valid & ~rst;
        if (redirect_valid) begin
          state_n = S_REQ;
        end else if (out_ready) begin
          out_fire = 1'b1;
          state_n  = S_REQ;
        end
      end
      default: begin
        state_n = S_REQ;
        drop_n  = 1'b0;
      end
    endcase
  end

`ifdef YSYX_IFU_PERF_EN
  assign in_wait = (state == S_WAIT);
`endif

endmodule

`default_nettype wire

// File: rtl/ysyx_ifu.sv
// ============================================================================
// ysyx_ifu: RV32 fetch unit owning the PC; one outstanding imem read.
// Optional counters enabled by YSYX_IFU_PERF_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module ysyx_ifu
  import ysyx_ifu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic       clk,
  input  logic       rst,
  ysyx_ifu_if.master bus
`ifdef YSYX_IFU_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  logic              req_valid;
  logic              out_valid;
  logic              rsp_take;
  logic              out_fire;
  logic [ADDR_W-1:0] pc;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_pc;
`ifdef YSYX_IFU_PERF_EN
  logic              in_wait;
`endif

  ysyx_ifu_fsm u_fsm (
    .clk            (clk),
    .rst            (rst),
    .req_ready      (bus.imem_req_ready),
    .rsp_valid      (bus.imem_rsp_valid),
    .out_ready      (bus.out_ready),
    .redirect_valid (bus.redirect_valid),
    .req_valid      (req_valid),
    .out_valid      (out_valid),
    .rsp_take       (rsp_take),
    .out_fire       (out_fire)
`ifdef YSYX_IFU_PERF_EN
    ,
    .in_wait        (in_wait)
`endif
  );

  // Redirect outranks the decode handoff; the PC wraps naturally on +4.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      out_inst <= 32'd0;
      out_pc   <= '0;
    end else begin
      if (bus.redirect_valid) begin
        pc <= bus.redirect_pc & ~ADDR_W'(3);
      end else if (out_fire) begin
        pc <= pc + ADDR_W'(4);
      end
      if (rsp_take) begin
        out_inst <= bus.imem_rsp_data;
        out_pc   <= pc;
      end
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc;
  assign bus.out_valid      = out_valid;
  assign bus.out_inst       = out_inst;
  assign bus.out_pc         = out_pc;

`ifdef YSYX_IFU_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (out_fire) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (in_wait)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire
